// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: multi-cycle load/store unit behind the instruction controller.
// Accepts one LOAD/STORE at a time, runs a req/gnt/rvalid handshake on the
// data-memory port, and returns sign/zero-extended load data with a done pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; legality check on the accepted request
// S_REQ  | mem_req high, address/strobes/data held until mem_gnt
// S_WAIT | request granted; waiting for mem_rvalid or the timeout count
// S_DONE | one-cycle completion: done=1, err valid, busy still high
module lsu_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [3:0]  dmem_wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last WAIT count before giving up; rvalid arriving on this count still wins.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        lat_is_store;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    logic        f3_ok;
    logic        align_ok;
    logic        req_legal;
    logic [3:0]  size_be;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Legality and lane alignment of the request currently on the inputs.
    always_comb begin
        f3_ok     = 1'b0;
        align_ok  = 1'b1;
        size_be   = 4'b1111;
        req_be    = 4'b0000;
        req_wdata = 32'h0;

        if (is_store) begin
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end

        case (funct3[1:0])
            2'b00:   size_be = 4'b0001;
            2'b01:   size_be = 4'b0011;
            default: size_be = 4'b1111;
        endcase

        case (funct3[1:0])
            2'b01:   align_ok = (addr[0] == 1'b0);
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase

        // Store strobes come from the controller unshifted; bits pushed past
        // lane 3 are dropped.
        if (is_store) begin
            req_be    = dmem_wr_en << addr[1:0];
            req_wdata = wdata << {addr[1:0], 3'b000};
        end else begin
            req_be    = size_be << addr[1:0];
            req_wdata = 32'h0;
        end
    end

    assign req_legal = f3_ok && align_ok;

    // Bring the addressed lane down to bit 0 and extend it by access type.
    always_comb begin
        lane     = mem_rdata >> {lat_off, 3'b000};
        load_ext = lane;
        case (lat_funct3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 8'h0;
            lat_is_store <= 1'b0;
            lat_funct3   <= 3'b000;
            lat_off      <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rdata        <= 32'h0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_be       <= 4'b0000;
            mem_wdata    <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_is_store <= is_store;
                        lat_funct3   <= funct3;
                        lat_off      <= addr[1:0];
                        busy         <= 1'b1;
                        if (req_legal) begin
                            state     <= S_REQ;
                            err       <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata;
                        end else begin
                            // Rejected without touching the memory port.
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    // rvalid before the grant is not a response to this request.
                    if (mem_gnt) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'h0;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (mem_rvalid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        if (!lat_is_store) begin
                            rdata <= load_ext;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        wait_cnt <= wait_cnt + 8'h1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end

                S_DONE: begin
                    // start is ignored here; it is accepted again from IDLE.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Multi-cycle load/store unit directly downstream of the instruction controller.
- Consumes the decoded store byte-enables (dmem_wr_en), funct3, the ALU-computed address and rs2 data.
- Performs a req/gnt/rvalid transaction on the data-memory port, and returns the sign/zero-extended load result to the register-file write mux.
- Asserts busy so the core stalls PC update while an access is outstanding.

Parameters:
- TIMEOUT, 255: max cycles in WAIT for mem_rvalid before aborting with err (1..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request for a LOAD/STORE; sampled only in IDLE
- is_store  input  1  1=store, 0=load; sampled with start
- funct3  input  3  access size/sign; sampled with start
- dmem_wr_en  input  4  controller byte enables, unshifted (0001/0011/1111); used for stores
- addr  input  32  byte address (ALU result); sampled with start
- wdata  input  32  store data (rs2); sampled with start
- busy  output  1  high from the cycle after accepted start through the done cycle
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned, illegal funct3, or timeout
- rdata  output  32  extended load data; valid with done, held until next done
- mem_req  output  1  memory request
- mem_we  output  1  write strobe, valid with mem_req
- mem_addr  output  32  word address {addr[31:2],2'b00}
- mem_be  output  4  shifted byte enables
- mem_wdata  output  32  lane-aligned store data
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  read data valid / write ack
- mem_rdata  input  32  raw read word

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; all outputs 0, including rdata; timeout counter 0.
  - Reset mid-transaction drops mem_req next cycle; a late mem_rvalid in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE:
  - start=1 latches is_store, funct3, dmem_wr_en, addr, wdata.
  - Check legality:
    - loads: funct3 in {000,001,010,100,101}; stores: funct3 in {000,001,010}.
    - halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Illegal → DONE with err=1, no memory access. Legal → REQ.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_gnt.
  - mem_gnt=1 → WAIT with counter cleared; mem_req deasserts the next cycle.
- WAIT:
  - mem_rvalid=1 → DONE.
    - Loads capture the extended mem_rdata into rdata.
    - Stores leave rdata unchanged.
  - Else counter++. Counter reaching TIMEOUT → DONE with err=1; rdata unchanged.
  - mem_rvalid in the same cycle as the final timeout count wins (no err).
- DONE: done=1 for exactly one cycle, err valid, busy=1; then IDLE.
- start is ignored when not in IDLE, including the DONE cycle. start is accepted again the cycle after done.
- Lane alignment, with off=addr[1:0]:
  - Stores: mem_be = dmem_wr_en << off (4-bit, truncated); mem_wdata = wdata << (8*off).
  - Loads: mem_be = (0001/0011/1111 by size) << off.
- Load extension: lane = mem_rdata >> (8*off).
  - LB: sign-extend lane[7:0]; LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0]; LHU: zero-extend lane[15:0].
  - LW: full word.
- Latency:
  - start at cycle 0, mem_gnt at cycle 1, mem_rvalid at cycle 2 → done at cycle 3 (minimum).
  - Misaligned/illegal requests → done at cycle 1.
- mem_gnt or mem_rvalid outside REQ/WAIT is ignored. mem_rvalid in REQ before gnt is ignored.

Test Plan:
- LB sign: addr=0x1003, mem_rdata=0x80_12_34_56, gnt and rvalid immediate → mem_addr=0x1000, mem_be=1000, done at cycle 3, rdata=0xFFFFFF80, err=0.
- LHU: addr=0x2002 → mem_be=1100; mem_rdata=0xBEEF0000 → rdata=0x0000BEEF.
- SB: addr=0x3001, wdata=0x000000AB, dmem_wr_en=0001 → mem_we=1, mem_be=0010, mem_wdata=0x0000AB00; rvalid ack → done, err=0, rdata unchanged.
- Misaligned LW: addr=0x4002 → mem_req stays 0, done at cycle 1 with err=1. Illegal store funct3=011 behaves the same.
- Stall/timeout with TIMEOUT=4:
  - gnt delayed 3 cycles → mem_req and all mem_* outputs held stable for 3 cycles.
  - No rvalid after gnt → err=1 with done after 4 WAIT cycles.
  - A start pulse during busy is ignored.
- Reset mid-WAIT: rst_n=0 one cycle → busy=0, mem_req=0, rdata=0. Then a stray mem_rvalid produces no done.
